// File: rtl/skolem_shl_ne_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the combinational Skolem netlist
// that solves (s << x) != t.
interface skolem_shl_ne_sweep_checker_if #(
    parameter int W = 4
);
    logic [W-1:0] sk_s;
    logic [W-1:0] sk_t;
    logic [W-1:0] sk_x;

    modport master (output sk_s, output sk_t, input sk_x);
    modport slave  (input sk_s, input sk_t, output sk_x);
endinterface

// File: rtl/skolem_shl_ne_sweep_checker.sv
// Exhaustive sweep checker for a Skolem netlist computing x with (s << x) != t.
// Walks every (s,t) pair, samples x after SETTLE cycles and tallies pass/fail results.
module skolem_shl_ne_sweep_checker #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    skolem_shl_ne_sweep_checker_if.master sk,
    output logic                  busy,
    output logic                  done,
    output logic [2*W:0]          pass_cnt,
    output logic [2*W:0]          fail_cnt,
    output logic                  fail_seen,
    output logic [3*W-1:0]        first_fail
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state;
    logic [2*W-1:0]    idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ic;
    logic              ok;
    logic [W-1:0]      sh;

    // bvshl: any shift amount of W or more clears every bit
    function automatic logic [W-1:0] shl_bv(input logic [W-1:0] a, input logic [W-1:0] amt);
        if ({1'b0, amt} >= (W+1)'(W))
            return '0;
        return a << amt;
    endfunction

    assign sk.sk_s = idx[W-1:0];
    assign sk.sk_t = idx[2*W-1:W];

    always_comb begin
        ic = (sk.sk_s != '0) || (sk.sk_t != '0);
        sh = shl_bv(sk.sk_s, sk.sk_x);
        ok = !ic || (sh != sk.sk_t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= DRIVE;
                        idx        <= '0;
                        wait_cnt   <= WAIT_INIT;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass_cnt   <= '0;
                        fail_cnt   <= '0;
                        fail_seen  <= 1'b0;
                        first_fail <= '0;
                    end
                end
                DRIVE: begin
                    if (wait_cnt == '0)
                        state <= SAMPLE;
                    else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                SAMPLE: begin
                    if (ok) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        fail_cnt  <= fail_cnt + 1'b1;
                        fail_seen <= 1'b1;
                        if (!fail_seen)
                            first_fail <= {sk.sk_s, sk.sk_t, sk.sk_x};
                    end
                    // The last pair parks idx at all-ones rather than wrapping
                    if (&idx) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx      <= idx + 1'b1;
                        wait_cnt <= WAIT_INIT;
                        state    <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_shl_ne_sweep_checker.sv
// Directed bench: two checkers (SETTLE=1 with combinational models, SETTLE=3 with a
// 2-cycle delayed model) swept exhaustively with hand-derived expected tallies.
module tb_skolem_shl_ne_sweep_checker;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int   mode = 0;

    logic          busy1, done1, fail_seen1;
    logic [2*W:0]  pass1, fail1;
    logic [3*W-1:0] ff1;
    logic          busy2, done2, fail_seen2;
    logic [2*W:0]  pass2, fail2;
    logic [3*W-1:0] ff2;

    logic [W-1:0] p1, p2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    skolem_shl_ne_sweep_checker_if #(.W(W)) sk1 ();
    skolem_shl_ne_sweep_checker_if #(.W(W)) sk2 ();

    skolem_shl_ne_sweep_checker #(.W(W), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sk(sk1.master),
        .busy(busy1), .done(done1), .pass_cnt(pass1), .fail_cnt(fail1),
        .fail_seen(fail_seen1), .first_fail(ff1));

    skolem_shl_ne_sweep_checker #(.W(W), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sk(sk2.master),
        .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
        .fail_seen(fail_seen2), .first_fail(ff2));

    // Mode 0 ideal; 1 stuck at zero; 2 IC-false/wide-shift model that always works;
    // 3 same idea but x=4 also for t=0, which fails for every s!=0
    function automatic logic [W-1:0] model(input logic [W-1:0] s, input logic [W-1:0] t, input int m);
        case (m)
            0: return (t != 0) ? 4'd4 : 4'd0;
            1: return 4'd0;
            2: return (t == 0) ? 4'd0 : ((s == 0 && t == 5) ? 4'd1 : 4'd4);
            default: return (s == 0 && t == 0) ? 4'd0 : ((s == 0 && t == 5) ? 4'd1 : 4'd4);
        endcase
    endfunction

    always_comb sk1.sk_x = model(sk1.sk_s, sk1.sk_t, mode);

    always @(posedge clk) begin
        p1 <= model(sk2.sk_s, sk2.sk_t, 0);
        p2 <= p1;
    end
    assign sk2.sk_x = p2;

    task automatic run_sweep(input int which, input int pulse_at, output int cycles);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        cycles = 0;
        while (!((which == 1) ? done1 : done2) && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (which == 1) start1 = (cycles == pulse_at);
        end
        start1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if ({busy1, done1, fail_seen1} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy1, done1, fail_seen1}); end
        checks++; if (pass1 !== 0 || fail1 !== 0) begin errors++; $display("FAIL reset_cnt got pass=%0d fail=%0d want 0/0", pass1, fail1); end
        checks++; if (ff1 !== 0) begin errors++; $display("FAIL reset_first_fail got %h want 000", ff1); end
        checks++; if (sk1.sk_s !== 0 || sk1.sk_t !== 0) begin errors++; $display("FAIL reset_operands got s=%0d t=%0d want 0/0", sk1.sk_s, sk1.sk_t); end
        checks++; if ({busy2, done2, pass2, fail2} !== '0) begin errors++; $display("FAIL reset_dut2 got busy=%b done=%b pass=%0d fail=%0d want zeros", busy2, done2, pass2, fail2); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL idle_hold got busy=%b done=%b want 0/0", busy1, done1); end
    endtask

    task automatic test_ideal_sweep();
        int cyc;
        mode = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy1); end
        repeat (2) @(negedge clk);
        checks++; if (sk1.sk_s !== 4'd1 || sk1.sk_t !== 4'd0) begin errors++; $display("FAIL pair1_operands got s=%0d t=%0d want 1/0", sk1.sk_s, sk1.sk_t); end
        cyc = 2;
        while (!done1 && cyc < 4000) begin @(negedge clk); cyc++; end
        checks++; if (cyc != 512) begin errors++; $display("FAIL ideal_length got %0d want 512", cyc); end
        checks++; if (pass1 !== 9'd256 || fail1 !== 9'd0 || fail_seen1 !== 1'b0) begin errors++; $display("FAIL ideal_counts got pass=%0d fail=%0d seen=%b want 256/0/0", pass1, fail1, fail_seen1); end
        checks++; if (busy1 !== 1'b0 || sk1.sk_s !== 4'hf || sk1.sk_t !== 4'hf) begin errors++; $display("FAIL ideal_end got busy=%b s=%h t=%h want 0/f/f", busy1, sk1.sk_s, sk1.sk_t); end
    endtask

    task automatic test_stuck_zero();
        int cyc;
        mode = 1;
        run_sweep(1, -1, cyc);
        checks++; if (cyc != 512) begin errors++; $display("FAIL stuck_length got %0d want 512", cyc); end
        checks++; if (pass1 !== 9'd241 || fail1 !== 9'd15) begin errors++; $display("FAIL stuck_counts got pass=%0d fail=%0d want 241/15", pass1, fail1); end
        checks++; if (fail_seen1 !== 1'b1 || ff1 !== 12'h110) begin errors++; $display("FAIL stuck_first got seen=%b first=%h want 1/110", fail_seen1, ff1); end
    endtask

    task automatic test_restart_from_done();
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL restart_flags got done=%b busy=%b want 0/1", done1, busy1); end
        checks++; if (pass1 !== 0 || fail1 !== 0 || fail_seen1 !== 0 || ff1 !== 0) begin errors++; $display("FAIL restart_clear got pass=%0d fail=%0d seen=%b first=%h want cleared", pass1, fail1, fail_seen1, ff1); end
        while (!done1) @(negedge clk);
    endtask

    task automatic test_ic_false_and_wide_shift();
        int cyc;
        mode = 2;
        run_sweep(1, -1, cyc);
        checks++; if (pass1 !== 9'd256 || fail1 !== 9'd0 || fail_seen1 !== 1'b0) begin errors++; $display("FAIL wide_ok_counts got pass=%0d fail=%0d seen=%b want 256/0/0", pass1, fail1, fail_seen1); end
        mode = 3;
        run_sweep(1, -1, cyc);
        checks++; if (pass1 !== 9'd241 || fail1 !== 9'd15) begin errors++; $display("FAIL wide_t0_counts got pass=%0d fail=%0d want 241/15", pass1, fail1); end
        checks++; if (ff1 !== 12'h104) begin errors++; $display("FAIL wide_t0_first got %h want 104", ff1); end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        mode = 0;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (200) @(negedge clk);
        checks++; if (sk1.sk_s !== 4'd4 || sk1.sk_t !== 4'd6 || pass1 !== 9'd100) begin errors++; $display("FAIL pair100 got s=%0d t=%0d pass=%0d want 4/6/100", sk1.sk_s, sk1.sk_t, pass1); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy1 !== 0 || done1 !== 0 || pass1 !== 0 || sk1.sk_s !== 0 || sk1.sk_t !== 0) begin errors++; $display("FAIL async_reset got busy=%b done=%b pass=%0d s=%0d t=%0d want zeros", busy1, done1, pass1, sk1.sk_s, sk1.sk_t); end
        @(negedge clk) rst_n = 1'b1;
        run_sweep(1, -1, cyc);
        checks++; if (pass1 + fail1 !== 10'd256 || cyc != 512) begin errors++; $display("FAIL post_reset_sweep got total=%0d len=%0d want 256/512", pass1 + fail1, cyc); end
    endtask

    task automatic test_start_while_busy();
        int cyc;
        mode = 0;
        run_sweep(1, 20, cyc);
        checks++; if (cyc != 512) begin errors++; $display("FAIL busy_start_length got %0d want 512", cyc); end
        checks++; if (pass1 !== 9'd256 || fail1 !== 9'd0) begin errors++; $display("FAIL busy_start_counts got pass=%0d fail=%0d want 256/0", pass1, fail1); end
    endtask

    task automatic test_settle3();
        int cyc;
        run_sweep(2, -1, cyc);
        checks++; if (cyc != 1024) begin errors++; $display("FAIL settle3_length got %0d want 1024", cyc); end
        checks++; if (pass2 !== 9'd256 || fail2 !== 9'd0 || fail_seen2 !== 1'b0) begin errors++; $display("FAIL settle3_counts got pass=%0d fail=%0d seen=%b want 256/0/0", pass2, fail2, fail_seen2); end
    endtask

    initial begin
        test_reset();
        test_ideal_sweep();
        test_stuck_zero();
        test_restart_from_done();
        test_ic_false_and_wide_shift();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
